// File: rtl/io_pkg.sv
// Shared IO-region page map and load-decode helper for the input/output buffers.
package io_pkg;

  localparam logic [19:0] IO_LEDR_PAGE   = 20'h10000;
  localparam logic [19:0] IO_LEDG_PAGE   = 20'h10001;
  localparam logic [19:0] IO_HEX_LO_PAGE = 20'h10002;
  localparam logic [19:0] IO_HEX_HI_PAGE = 20'h10003;
  localparam logic [19:0] IO_LCD_PAGE    = 20'h10004;

  localparam logic [19:0] IO_SW_PAGE     = 20'h10010;
  localparam logic [19:0] IO_BTN_PAGE    = 20'h10011;
  localparam logic [19:0] IO_FLAG_PAGE   = 20'h10012;

  typedef enum logic [1:0] {
    RD_NONE,
    RD_SW,
    RD_BTN,
    RD_FLAG
  } rd_sel_e;

  function automatic rd_sel_e decode_rd(input logic [19:0] page);
    case (page)
      IO_SW_PAGE:   decode_rd = RD_SW;
      IO_BTN_PAGE:  decode_rd = RD_BTN;
      IO_FLAG_PAGE: decode_rd = RD_FLAG;
      default:      decode_rd = RD_NONE;
    endcase
  endfunction

endpackage

// File: rtl/btn_debounce.sv
// One push-button: 2-flop synchronizer, consecutive-difference counter and
// stable level, with a single-cycle pulse on a debounced press (1->0).
module btn_debounce #(
  parameter int DB_CNT_W = 16,
  parameter int DB_LIMIT = 50000
) (
  input  logic i_clk,
  input  logic i_reset,
  input  logic i_btn,
  output logic o_stable,
  output logic o_press_pulse
);

  logic                r_sync1;
  logic                r_sync2;
  logic                r_stable;
  logic [DB_CNT_W-1:0] r_cnt;
  logic                w_diff;
  logic                w_done;

  assign w_diff = (r_sync2 != r_stable);
  assign w_done = w_diff && (r_cnt == DB_CNT_W'(DB_LIMIT - 1));

  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset) begin
      r_sync1  <= 1'b1;
      r_sync2  <= 1'b1;
      r_stable <= 1'b1;
      r_cnt    <= '0;
    end else begin
      r_sync1 <= i_btn;
      r_sync2 <= r_sync1;
      // Any match clears the count, so it never wraps within its width.
      if (!w_diff) begin
        r_cnt <= '0;
      end else if (w_done) begin
        r_stable <= r_sync2;
        r_cnt    <= '0;
      end else begin
        r_cnt <= r_cnt + DB_CNT_W'(1);
      end
    end
  end

  assign o_stable      = r_stable;
  assign o_press_pulse = w_done && r_stable && !r_sync2;

endmodule

// File: rtl/input_buffer.sv
// Memory-mapped input peripheral: synced switches, debounced buttons, sticky
// W1C press flags, registered load data and a level button interrupt.
module input_buffer
  import io_pkg::*;
#(
  parameter int DB_CNT_W = 16,
  parameter int DB_LIMIT = 50000,
  parameter int NUM_BTN  = 4
) (
  input  logic               i_clk,
  input  logic               i_reset,
  input  logic [31:0]        i_io_sw,
  input  logic [NUM_BTN-1:0] i_io_btn,
  input  logic [31:0]        i_io_addr,
  input  logic               i_io_rden,
  input  logic               f_io_wren,
  input  logic [31:0]        i_st_data,
  output logic [31:0]        o_ld_data,
  output logic               o_ld_valid,
  output logic               o_btn_irq
);

  logic [31:0]        r_sw_sync1;
  logic [31:0]        r_sw_sync2;
  logic [NUM_BTN-1:0] r_flags;
  logic [NUM_BTN-1:0] w_stable;
  logic [NUM_BTN-1:0] w_press;
  logic [NUM_BTN-1:0] w_clr;
  logic [31:0]        w_rd_data;
  logic               w_unused;

  assign w_unused = ^{i_io_addr[11:0], i_st_data[31:NUM_BTN]};

  for (genvar k = 0; k < NUM_BTN; k++) begin : g_btn
    btn_debounce #(
      .DB_CNT_W(DB_CNT_W),
      .DB_LIMIT(DB_LIMIT)
    ) u_db (
      .i_clk        (i_clk),
      .i_reset      (i_reset),
      .i_btn        (i_io_btn[k]),
      .o_stable     (w_stable[k]),
      .o_press_pulse(w_press[k])
    );
  end

  assign w_clr = (f_io_wren && (i_io_addr[31:12] == IO_FLAG_PAGE))
               ? i_st_data[NUM_BTN-1:0] : '0;

  always_comb begin
    w_rd_data = '0;
    case (decode_rd(i_io_addr[31:12]))
      RD_SW:   w_rd_data = r_sw_sync2;
      RD_BTN:  w_rd_data[NUM_BTN-1:0] = ~w_stable;
      RD_FLAG: w_rd_data[NUM_BTN-1:0] = r_flags;
      default: w_rd_data = '0;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset) begin
      r_sw_sync1 <= '0;
      r_sw_sync2 <= '0;
      r_flags    <= '0;
      o_ld_data  <= '0;
      o_ld_valid <= 1'b0;
      o_btn_irq  <= 1'b0;
    end else begin
      r_sw_sync1 <= i_io_sw;
      r_sw_sync2 <= r_sw_sync1;
      // Set is OR'd after the clear mask so a same-cycle press survives.
      r_flags    <= (r_flags & ~w_clr) | w_press;
      o_btn_irq  <= |r_flags;
      o_ld_valid <= i_io_rden;
      if (i_io_rden) begin
        o_ld_data <= w_rd_data;
      end
    end
  end

endmodule

// File: tb/tb_input_buffer.sv
// Directed bench for input_buffer with a load-data scoreboard (DB_LIMIT=8).
module tb_input_buffer;

  localparam int NUM_BTN = 4;
  localparam logic [31:0] A_SW   = 32'h1001_0000;
  localparam logic [31:0] A_BTN  = 32'h1001_1000;
  localparam logic [31:0] A_FLAG = 32'h1001_2000;

  logic               i_clk = 1'b0;
  logic               i_reset;
  logic [31:0]        i_io_sw;
  logic [NUM_BTN-1:0] i_io_btn;
  logic [31:0]        i_io_addr;
  logic               i_io_rden;
  logic               f_io_wren;
  logic [31:0]        i_st_data;
  logic [31:0]        o_ld_data;
  logic               o_ld_valid;
  logic               o_btn_irq;

  int n_checks = 0;
  int n_errors = 0;
  logic [31:0] exp_q[$];

  input_buffer #(
    .DB_CNT_W(16),
    .DB_LIMIT(8),
    .NUM_BTN (NUM_BTN)
  ) dut (
    .i_clk     (i_clk),
    .i_reset   (i_reset),
    .i_io_sw   (i_io_sw),
    .i_io_btn  (i_io_btn),
    .i_io_addr (i_io_addr),
    .i_io_rden (i_io_rden),
    .f_io_wren (f_io_wren),
    .i_st_data (i_st_data),
    .o_ld_data (o_ld_data),
    .o_ld_valid(o_ld_valid),
    .o_btn_irq (o_btn_irq)
  );

  always #5 i_clk = ~i_clk;

  task automatic check32(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge i_clk);
  endtask

  // Called at a negedge; the load is captured at the next posedge.
  task automatic rd(input string tag, input logic [31:0] addr, input logic [31:0] exp);
    exp_q.push_back(exp);
    i_io_addr = addr;
    i_io_rden = 1'b1;
    @(negedge i_clk);
    i_io_rden = 1'b0;
    check32({tag, "_valid"}, {31'b0, o_ld_valid}, 32'h1);
    if (exp_q.size() > 0) check32(tag, o_ld_data, exp_q.pop_front());
  endtask

  task automatic wr(input logic [31:0] addr, input logic [31:0] data);
    i_io_addr = addr;
    i_st_data = data;
    f_io_wren = 1'b1;
    @(negedge i_clk);
    f_io_wren = 1'b0;
  endtask

  initial begin
    i_reset   = 1'b0;
    i_io_sw   = '0;
    i_io_btn  = '1;
    i_io_addr = '0;
    i_io_rden = 1'b0;
    f_io_wren = 1'b0;
    i_st_data = '0;
    tick(2);
    check32("rst_ld_data", o_ld_data, 32'h0);
    check32("rst_ld_valid", {31'b0, o_ld_valid}, 32'h0);
    check32("rst_irq", {31'b0, o_btn_irq}, 32'h0);
    i_reset = 1'b1;
    tick(1);

    rd("rst_rd_sw", A_SW, 32'h0);
    rd("rst_rd_btn", A_BTN, 32'h0);
    rd("rst_rd_flag", A_FLAG, 32'h0);
    tick(1);
    check32("valid_drop", {31'b0, o_ld_valid}, 32'h0);
    check32("rst_irq_after", {31'b0, o_btn_irq}, 32'h0);

    // Switch sync latency
    i_io_sw = 32'hA5A5_00FF;
    rd("sw_plus1", A_SW, 32'h0);
    tick(1);
    rd("sw_plus3", A_SW, 32'hA5A5_00FF);
    tick(2);
    check32("ld_hold", o_ld_data, 32'hA5A5_00FF);

    // Bounce rejection on button 2
    repeat (3) begin
      i_io_btn[2] = 1'b0;
      tick(5);
      i_io_btn[2] = 1'b1;
      tick(3);
    end
    tick(4);
    rd("bounce_btn", A_BTN, 32'h0);
    rd("bounce_flag", A_FLAG, 32'h0);
    check32("bounce_irq", {31'b0, o_btn_irq}, 32'h0);

    // Stable press on button 1: flag sets on the 10th edge
    i_io_btn[1] = 1'b0;
    tick(9);
    rd("press_pre", A_FLAG, 32'h0);
    check32("press_irq_pre", {31'b0, o_btn_irq}, 32'h0);
    rd("press_flag", A_FLAG, 32'h2);
    check32("press_irq", {31'b0, o_btn_irq}, 32'h1);
    rd("press_btn", A_BTN, 32'h2);

    // Write-1-to-clear
    i_io_btn[2] = 1'b0;
    tick(12);
    rd("w1c_flags0110", A_FLAG, 32'h6);
    rd("w1c_btn0110", A_BTN, 32'h6);
    wr(A_FLAG, 32'h4);
    rd("w1c_clr4", A_FLAG, 32'h2);
    wr(A_SW, 32'hF);
    rd("w1c_other_addr", A_FLAG, 32'h2);
    i_io_btn[1] = 1'b1;
    tick(12);
    rd("release_no_set", A_FLAG, 32'h2);
    wr(A_FLAG, 32'h2);
    rd("w1c_clr2", A_FLAG, 32'h0);
    check32("irq_clear", {31'b0, o_btn_irq}, 32'h0);

    // Set wins over a same-cycle clear
    i_io_btn[1] = 1'b0;
    tick(9);
    wr(A_FLAG, 32'h2);
    rd("set_wins", A_FLAG, 32'h2);

    // Read and clear in the same cycle returns pre-clear flags
    exp_q.push_back(32'h2);
    i_io_addr = A_FLAG;
    i_st_data = 32'h2;
    i_io_rden = 1'b1;
    f_io_wren = 1'b1;
    @(negedge i_clk);
    i_io_rden = 1'b0;
    f_io_wren = 1'b0;
    check32("rdwr_valid", {31'b0, o_ld_valid}, 32'h1);
    if (exp_q.size() > 0) check32("rdwr_preclear", o_ld_data, exp_q.pop_front());
    rd("rdwr_after", A_FLAG, 32'h0);

    // Low address bits ignored, unmapped pages read zero
    rd("sw_lowbits", 32'h1001_0ABC, 32'hA5A5_00FF);
    rd("unmapped", 32'h1001_3000, 32'h0);
    rd("sw_again", A_SW, 32'hA5A5_00FF);
    rd("led_page", 32'h1000_0000, 32'h0);

    // Reset in the middle of a debounce window
    i_io_btn = '1;
    tick(12);
    i_io_btn[0] = 1'b0;
    tick(5);
    i_reset = 1'b0;
    tick(1);
    check32("midrst_ld_data", o_ld_data, 32'h0);
    check32("midrst_valid", {31'b0, o_ld_valid}, 32'h0);
    check32("midrst_irq", {31'b0, o_btn_irq}, 32'h0);
    i_reset = 1'b1;
    tick(9);
    rd("midrst_pre", A_FLAG, 32'h0);
    check32("midrst_irq_pre", {31'b0, o_btn_irq}, 32'h0);
    rd("midrst_set", A_FLAG, 32'h1);
    check32("midrst_irq_set", {31'b0, o_btn_irq}, 32'h1);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
